// File: rtl/bus_arbiter.sv
// Round-robin grant of the shared L2/memory bus to NUM_REQ cache controllers.
// Latency: grant visible one cycle after the request is sampled in IDLE; two dead cycles between owners.
// Backpressure: requests are level-held; non-owners wait, owner keeps the bus until it drops req.
// Optional build macro ARB_TIMEOUT_EN: revokes a grant after HOLD_MAX cycles and pulses timeout_err.
module bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_arb,
  output logic [NUM_REQ-1:0] gnt_arb,
  output logic               bus_busy,
  output logic [IDX_W-1:0]   owner_idx,
  output logic               timeout_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Reject configurations the arbiter cannot honour at elaboration time.
  if (NUM_REQ < 2 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("bus_arbiter: NUM_REQ must be >= 2 and HOLD_MAX >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int             HOLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tout_q, tout_d;
`endif

  // (base + off) mod NUM_REQ without relying on a power-of-two requester count.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int c;
    c = int'(base) + off;
    if (c >= NUM_REQ) c = c - NUM_REQ;
    return c[IDX_W-1:0];
  endfunction

  // Winner search starting just above the last owner; walking down from the far end
  // lets the nearest candidate overwrite the others, so ptr_q itself ranks last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_arb[rr_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(ptr_q, i);
      end
    end
  end

  // Next-state logic for the IDLE -> GRANT -> RELEASE turnaround FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_idx;
          state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        // No preemption: only the owner's own request decides when the bus frees up.
        if (!req_arb[owner_q]) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          // ptr already equals the owner, so the revoked cache ranks last next round.
          gnt_d   = '0;
          state_d = ST_RELEASE;
          tout_d  = 1'b1;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset points ptr at the top requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      tout_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tout_q <= tout_d;
    end
  end

  assign timeout_err = tout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt_arb   = gnt_q;
  assign bus_busy  = |gnt_q;
  assign owner_idx = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomised checks of bus_arbiter grant order, turnaround gaps and reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req level until they have used their grant.
module tb_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int IDX_W    = 2;
  localparam int HOLD_MAX = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req_arb = '0;
  logic [NUM_REQ-1:0] gnt_arb;
  logic               bus_busy;
  logic [IDX_W-1:0]   owner_idx;
  logic               timeout_err;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_arb     (req_arb),
    .gnt_arb     (gnt_arb),
    .bus_busy    (bus_busy),
    .owner_idx   (owner_idx),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_arb = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic flush();
    req_arb = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_arb = 4'b1111;
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt_arb); end
    n_vec++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
    n_vec++; if (owner_idx !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner_idx); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_tout: got %b want 0", timeout_err); end
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL reset_hold_gnt: got %b want 0000", gnt_arb); end
    rst = 1'b0;
    req_arb = '0;
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL idle_noreq_gnt: got %b want 0000", gnt_arb); end
  endtask

  task automatic test_single_grant();
    req_arb = 4'b0001;
    tick();
    n_vec++; if (gnt_arb !== 4'b0001) begin n_err++; $display("FAIL single_gnt: got %b want 0001", gnt_arb); end
    n_vec++; if (bus_busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", bus_busy); end
    n_vec++; if (owner_idx !== 2'd0) begin n_err++; $display("FAIL single_owner: got %0d want 0", owner_idx); end
    tick();
    n_vec++; if (gnt_arb !== 4'b0001) begin n_err++; $display("FAIL single_held: got %b want 0001", gnt_arb); end
    req_arb = 4'b0000;
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL single_drop: got %b want 0000", gnt_arb); end
    n_vec++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL single_drop_busy: got %b want 0", bus_busy); end
    n_vec++; if (owner_idx !== 2'd0) begin n_err++; $display("FAIL single_owner_kept: got %0d want 0", owner_idx); end
    tick();
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL single_idle: got %b want 0000", gnt_arb); end
  endtask

  task automatic test_rotation();
    logic [NUM_REQ-1:0] exp_g;
    do_reset();
    req_arb = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      for (int c = 0; c < 3; c++) begin
        n_vec++; if (gnt_arb !== exp_g) begin n_err++; $display("FAIL rot_gnt g%0d c%0d: got %b want %b", g, c, gnt_arb, exp_g); end
        if (c < 2) tick();
      end
      n_vec++; if (owner_idx !== IDX_W'(g % 4)) begin n_err++; $display("FAIL rot_owner g%0d: got %0d want %0d", g, owner_idx, g % 4); end
      req_arb = req_arb & ~exp_g;
      tick();
      n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL rot_gap1 g%0d: got %b want 0000", g, gnt_arb); end
      req_arb = 4'b1111;
      tick();
      n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL rot_gap2 g%0d: got %b want 0000", g, gnt_arb); end
      tick();
    end
    flush();
  endtask

  task automatic test_handoff();
    do_reset();
    req_arb = 4'b0100;
    tick();
    n_vec++; if (gnt_arb !== 4'b0100) begin n_err++; $display("FAIL hand_first: got %b want 0100", gnt_arb); end
    tick();
    req_arb = 4'b1000;
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL hand_gap1: got %b want 0000", gnt_arb); end
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL hand_gap2: got %b want 0000", gnt_arb); end
    tick();
    n_vec++; if (gnt_arb !== 4'b1000) begin n_err++; $display("FAIL hand_next: got %b want 1000", gnt_arb); end
    n_vec++; if (owner_idx !== 2'd3) begin n_err++; $display("FAIL hand_owner: got %0d want 3", owner_idx); end
    flush();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_arb = 4'b0100;
    tick();
    tick();
    n_vec++; if (gnt_arb !== 4'b0100) begin n_err++; $display("FAIL midrst_pre: got %b want 0100", gnt_arb); end
    rst = 1'b1;
    req_arb = 4'b0101;
    tick();
    n_vec++; if (gnt_arb !== 4'b0000) begin n_err++; $display("FAIL midrst_drop: got %b want 0000", gnt_arb); end
    n_vec++; if (owner_idx !== 2'd0) begin n_err++; $display("FAIL midrst_owner: got %0d want 0", owner_idx); end
    rst = 1'b0;
    tick();
    n_vec++; if (gnt_arb !== 4'b0001) begin n_err++; $display("FAIL midrst_regrant: got %b want 0001", gnt_arb); end
    n_vec++; if (owner_idx !== 2'd0) begin n_err++; $display("FAIL midrst_reowner: got %0d want 0", owner_idx); end
    flush();
  endtask

  task automatic test_timeout();
    logic eg;
    logic et;
    int   pos;
    do_reset();
    req_arb = 4'b0010;
    for (int c = 1; c <= 40; c++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      pos = (c - 1) % (HOLD_MAX + 2);
      eg  = (pos < HOLD_MAX);
      et  = (pos == HOLD_MAX);
`else
      pos = c;
      eg  = 1'b1;
      et  = 1'b0;
`endif
      n_vec++; if (gnt_arb !== (eg ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL tout_gnt c%0d(pos %0d): got %b want %b", c, pos, gnt_arb, eg ? 4'b0010 : 4'b0000); end
      n_vec++; if (timeout_err !== et) begin n_err++; $display("FAIL tout_pulse c%0d: got %b want %b", c, timeout_err, et); end
    end
    flush();
  endtask

  task automatic test_random();
    int waitc [NUM_REQ];
    int gcnt  [NUM_REQ];
    int glim  [NUM_REQ];
    int bound;
    bound = (NUM_REQ - 1) * (4 + 2) + 2;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      waitc[i] = 0;
      gcnt[i]  = 0;
      glim[i]  = $urandom_range(1, 4);
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_arb[i]) begin
          gcnt[i]++;
          if (gcnt[i] >= glim[i]) begin
            req_arb[i] = 1'b0;
            gcnt[i] = 0;
            glim[i] = $urandom_range(1, 4);
          end
        end else if (!req_arb[i] && $urandom_range(0, 3) == 0) begin
          req_arb[i] = 1'b1;
        end
      end
      tick();
      n_vec++; if (!$onehot0(gnt_arb)) begin n_err++; $display("FAIL rand_onehot cyc%0d: got %b want onehot0", cyc, gnt_arb); end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_arb[i] && !gnt_arb[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > bound) begin
          n_vec++; n_err++;
          $display("FAIL rand_starve req%0d cyc%0d: waited %0d want <= %0d", i, cyc, waitc[i], bound);
          waitc[i] = 0;
        end
      end
    end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rand_tout: got %b want 0", timeout_err); end
    flush();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_handoff();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
